// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a simple dual-port RAM: independent round-robin
// arbitration of the read and write ports, 1-cycle tagged read return.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data to a colliding read.
module ram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_rd_req,
    input  logic [ADDR_W-1:0] a_rd_addr,
    output logic              a_rd_gnt,
    output logic              a_rd_valid,
    output logic [DATA_W-1:0] a_rd_data,
    input  logic              a_wr_req,
    input  logic [ADDR_W-1:0] a_wr_addr,
    input  logic [DATA_W-1:0] a_wr_data,
    output logic              a_wr_gnt,
    input  logic              b_rd_req,
    input  logic [ADDR_W-1:0] b_rd_addr,
    output logic              b_rd_gnt,
    output logic              b_rd_valid,
    output logic [DATA_W-1:0] b_rd_data,
    input  logic              b_wr_req,
    input  logic [ADDR_W-1:0] b_wr_addr,
    input  logic [DATA_W-1:0] b_wr_data,
    output logic              b_wr_gnt,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr_write,
    output logic [DATA_W-1:0] ram_data_write,
    output logic [ADDR_W-1:0] ram_addr_read,
    input  logic [DATA_W-1:0] ram_data_read
);

    // *_last_b_q = 1 means B was served last, so A wins the next contention.
    logic rd_last_b_q, rd_last_b_d;
    logic wr_last_b_q, wr_last_b_d;
    logic tag_valid_q, tag_valid_d;
    logic tag_owner_q, tag_owner_d;
    logic rd_any, wr_any;
    logic [DATA_W-1:0] rd_ret_data;

    always_comb begin
        a_rd_gnt = rst_n & a_rd_req & (~b_rd_req | rd_last_b_q);
        b_rd_gnt = rst_n & b_rd_req & (~a_rd_req | ~rd_last_b_q);
        a_wr_gnt = rst_n & a_wr_req & (~b_wr_req | wr_last_b_q);
        b_wr_gnt = rst_n & b_wr_req & (~a_wr_req | ~wr_last_b_q);
        rd_any   = a_rd_gnt | b_rd_gnt;
        wr_any   = a_wr_gnt | b_wr_gnt;

        rd_last_b_d = rd_last_b_q;
        if (a_rd_gnt)      rd_last_b_d = 1'b0;
        else if (b_rd_gnt) rd_last_b_d = 1'b1;
        wr_last_b_d = wr_last_b_q;
        if (a_wr_gnt)      wr_last_b_d = 1'b0;
        else if (b_wr_gnt) wr_last_b_d = 1'b1;

        ram_write      = wr_any;
        ram_addr_write = '0;
        ram_data_write = '0;
        if (a_wr_gnt) begin
            ram_addr_write = a_wr_addr;
            ram_data_write = a_wr_data;
        end else if (b_wr_gnt) begin
            ram_addr_write = b_wr_addr;
            ram_data_write = b_wr_data;
        end

        ram_addr_read = '0;
        if (a_rd_gnt)      ram_addr_read = a_rd_addr;
        else if (b_rd_gnt) ram_addr_read = b_rd_addr;

        tag_valid_d = rd_any;
        tag_owner_d = b_rd_gnt;
    end

`ifdef WRITE_BYPASS_EN
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    always_comb begin
        hit_d      = rd_any & wr_any & (ram_addr_read == ram_addr_write);
        byp_data_d = ram_data_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            hit_q      <= hit_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign rd_ret_data = hit_q ? byp_data_q : ram_data_read;
`else
    assign rd_ret_data = ram_data_read;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_last_b_q <= 1'b1;
            wr_last_b_q <= 1'b1;
            tag_valid_q <= 1'b0;
            tag_owner_q <= 1'b0;
        end else begin
            rd_last_b_q <= rd_last_b_d;
            wr_last_b_q <= wr_last_b_d;
            tag_valid_q <= tag_valid_d;
            tag_owner_q <= tag_owner_d;
        end
    end

    always_comb begin
        a_rd_valid = tag_valid_q & ~tag_owner_q;
        b_rd_valid = tag_valid_q & tag_owner_q;
        a_rd_data  = a_rd_valid ? rd_ret_data : '0;
        b_rd_data  = b_rd_valid ? rd_ret_data : '0;
    end

endmodule
